gray_count_tracker: RTL and testbench

//  Receive end of the gray_udl counter interface. Samples a Gray-coded count every clock and decodes it to binary.

---
 rtl/gray_pkg.sv | 35 +++
 rtl/gray_count_tracker_if.sv | 30 +++
 rtl/gray2bin_dec.sv | 15 +
 rtl/gray_count_tracker.sv | 108 ++++++++++
 tb/tb_gray_count_tracker.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// gray_pkg
//   Shared types and helpers for the Gray-count receive path.
//   trk_state_t : tracker FSM states (INIT / TRACK / FAULT)
//   gray2bin    : Gray-to-binary decode of the low w bits of g
package gray_pkg;

    typedef enum logic [1:0] {
        INIT,
        TRACK,
        FAULT
    } trk_state_t;

    localparam int unsigned GRAY_MAX_W = 32;

    // Walks from the MSB down, carrying the running XOR of the Gray bits.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] g,
        input int unsigned           w
    );
        logic [GRAY_MAX_W-1:0] b;
        logic                  acc;
        int unsigned           idx;
        b   = '0;
        acc = 1'b0;
        for (int unsigned k = 0; k < GRAY_MAX_W; k++) begin
            idx = GRAY_MAX_W - 1 - k;
            if (idx < w) begin
                acc    = acc ^ g[idx];
                b[idx] = acc;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_count_tracker_if.sv
// gray_count_tracker_if
//   Bundle between a Gray-count source / control side (master) and the
//   tracker (slave).
//   master drives : gray_in, resync, err_clr
//   slave drives  : bin_out, pos, step_up, step_dn, wrap, err, locked
interface gray_count_tracker_if #(
    parameter int unsigned W     = 3,
    parameter int unsigned POS_W = 8
);
    logic [W-1:0]     gray_in;
    logic             resync;
    logic             err_clr;
    logic [W-1:0]     bin_out;
    logic [POS_W-1:0] pos;
    logic             step_up;
    logic             step_dn;
    logic             wrap;
    logic             err;
    logic             locked;

    modport master (
        output gray_in, resync, err_clr,
        input  bin_out, pos, step_up, step_dn, wrap, err, locked
    );

    modport slave (
        input  gray_in, resync, err_clr,
        output bin_out, pos, step_up, step_dn, wrap, err, locked
    );
endinterface

// File: rtl/gray2bin_dec.sv
// gray2bin_dec
//   Combinational W-bit Gray-to-binary decoder (XOR prefix from the MSB).
//   gray_i : Gray-coded input
//   bin_o  : binary equivalent
module gray2bin_dec #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);
    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[W-1:i];
    end
endmodule

// File: rtl/gray_count_tracker.sv
// gray_count_tracker
//   Samples a Gray-coded count every clock, decodes it, classifies the
//   transition (hold / +1 / -1 / illegal) and keeps an extended signed
//   position across wrap-arounds.
//   clk, reset : clock, asynchronous active-high reset
//   trk.gray_in, trk.resync, trk.err_clr : inputs from the source side
//   trk.bin_out, trk.pos                 : registered decode and position
//   trk.step_up, trk.step_dn, trk.wrap   : one-cycle registered pulses
//   trk.err (sticky), trk.locked (TRACK) : status
module gray_count_tracker
    import gray_pkg::*;
#(
    parameter int unsigned W     = 3,
    parameter int unsigned POS_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    gray_count_tracker_if.slave  trk
);
    localparam logic [W-1:0]     ONE_W   = W'(1);
    localparam logic [POS_W-1:0] ONE_POS = POS_W'(1);

    trk_state_t       state_q, state_d;
    logic [W-1:0]     bin_q, bin_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             up_q, up_d;
    logic             dn_q, dn_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic [W-1:0]     dec_bin;
    logic [W-1:0]     delta;
    logic             illegal;

    gray2bin_dec #(.W(W)) u_dec (
        .gray_i (trk.gray_in),
        .bin_o  (dec_bin)
    );

    assign delta   = dec_bin - bin_q;
    assign illegal = (delta != '0) && (delta != ONE_W) && (delta != '1);

    // State register and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            bin_q   <= '0;
            pos_q   <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            pos_q   <= pos_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    state_d = TRACK;
            TRACK:   if (!trk.resync && illegal) state_d = FAULT;
            FAULT:   if (trk.err_clr || trk.resync) state_d = TRACK;
            default: state_d = INIT;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        // Every branch (load, resync, hold, step, illegal, fault-follow)
        // ends with bin_out equal to the current decode, so it is hoisted.
        bin_d  = dec_bin;
        pos_d  = pos_q;
        up_d   = 1'b0;
        dn_d   = 1'b0;
        wrap_d = 1'b0;
        // Clear first so an illegal step in the same cycle re-sets it.
        err_d  = trk.err_clr ? 1'b0 : err_q;
        if (state_q == TRACK && !trk.resync) begin
            if (delta == ONE_W) begin
                up_d   = 1'b1;
                pos_d  = pos_q + ONE_POS;
                wrap_d = &bin_q;
            end else if (delta == '1) begin
                dn_d   = 1'b1;
                pos_d  = pos_q - ONE_POS;
                wrap_d = (bin_q == '0);
            end else if (illegal) begin
                err_d  = 1'b1;
            end
        end
    end

    assign trk.bin_out = bin_q;
    assign trk.pos     = pos_q;
    assign trk.step_up = up_q;
    assign trk.step_dn = dn_q;
    assign trk.wrap    = wrap_q;
    assign trk.err     = err_q;
    assign trk.locked  = (state_q == TRACK);
endmodule

// File: tb/tb_gray_count_tracker.sv
// tb_gray_count_tracker
//   Directed vector table, hand sequences for asynchronous reset, and a
//   randomized run against a behavioural reference model.
module tb_gray_count_tracker;
    localparam int unsigned W     = 3;
    localparam int unsigned POS_W = 8;

    logic clk;
    logic reset;

    gray_count_tracker_if #(.W(W), .POS_W(POS_W)) bus ();

    gray_count_tracker #(.W(W), .POS_W(POS_W)) dut (
        .clk   (clk),
        .reset (reset),
        .trk   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [2:0] g;
        logic       rs;
        logic       ec;
        int         bin;
        int         pos;
        int         up;
        int         dn;
        int         wr;
        int         er;
        int         lk;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic [2:0] g, input logic rs, input logic ec,
                                input int bin, input int pos, input int up, input int dn,
                                input int wr, input int er, input int lk);
        vec_t v;
        v.g = g; v.rs = rs; v.ec = ec; v.bin = bin; v.pos = pos;
        v.up = up; v.dn = dn; v.wr = wr; v.er = er; v.lk = lk;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int bin, input int pos, input int up,
                           input int dn, input int wr, input int er, input int lk);
        chk({tag, ".bin"},    32'(bus.bin_out), bin);
        chk({tag, ".pos"},    32'(bus.pos),     pos & 255);
        chk({tag, ".up"},     32'(bus.step_up), up);
        chk({tag, ".dn"},     32'(bus.step_dn), dn);
        chk({tag, ".wrap"},   32'(bus.wrap),    wr);
        chk({tag, ".err"},    32'(bus.err),     er);
        chk({tag, ".locked"}, 32'(bus.locked),  lk);
    endtask

    // Drive after an edge, let the next rising edge sample, check at negedge.
    task automatic drive(input logic [2:0] g, input logic rs, input logic ec);
        bus.gray_in = g;
        bus.resync  = rs;
        bus.err_clr = ec;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.gray_in = '0;
        bus.resync  = 1'b0;
        bus.err_clr = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [2:0] enc(input int b);
        logic [2:0] v;
        v = 3'(b);
        return v ^ (v >> 1);
    endfunction

    // Reference model: mode 0 = awaiting first sample, 1 = tracking, 2 = faulted
    int m_mode, m_bin, m_pos, m_err, m_up, m_dn, m_wr;

    function automatic void model_step(input int b, input bit rs, input bit ec);
        int d;
        bit bad;
        m_up = 0; m_dn = 0; m_wr = 0;
        bad = 0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            d = (b - m_bin + 8) % 8;
            if (!rs) begin
                if (d == 1) begin
                    m_up = 1; m_pos = m_pos + 1; m_wr = (m_bin == 7);
                end else if (d == 7) begin
                    m_dn = 1; m_pos = m_pos - 1; m_wr = (m_bin == 0);
                end else if (d != 0) begin
                    bad = 1; m_mode = 2;
                end
            end
        end else begin
            if (ec || rs) m_mode = 1;
        end
        if (ec) m_err = 0;
        if (bad) m_err = 1;
        m_bin = b;
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bus.gray_in = '0;
        bus.resync  = 1'b0;
        bus.err_clr = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        //    g       rs ec bin pos up dn wr er lk
        // up count
        add(3'b000, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        add(3'b001, 0, 0, 1, 1,  1, 0, 0, 0, 1);
        add(3'b011, 0, 0, 2, 2,  1, 0, 0, 0, 1);
        add(3'b010, 0, 0, 3, 3,  1, 0, 0, 0, 1);
        add(3'b110, 0, 0, 4, 4,  1, 0, 0, 0, 1);
        add(3'b110, 0, 0, 4, 4,  0, 0, 0, 0, 1);
        // up wrap
        add(3'b111, 0, 0, 5, 5,  1, 0, 0, 0, 1);
        add(3'b101, 0, 0, 6, 6,  1, 0, 0, 0, 1);
        add(3'b100, 0, 0, 7, 7,  1, 0, 0, 0, 1);
        add(3'b000, 0, 0, 0, 8,  1, 0, 1, 0, 1);
        // down wrap
        add(3'b100, 0, 0, 7, 7,  0, 1, 1, 0, 1);
        add(3'b101, 0, 0, 6, 6,  0, 1, 0, 0, 1);
        add(3'b100, 0, 0, 7, 7,  1, 0, 0, 0, 1);
        add(3'b000, 0, 0, 0, 8,  1, 0, 1, 0, 1);
        // illegal jump, recover with err_clr
        add(3'b011, 0, 0, 2, 8,  0, 0, 0, 1, 0);
        add(3'b010, 0, 1, 3, 8,  0, 0, 0, 0, 1);
        // err_clr together with illegal step: set wins
        add(3'b000, 0, 1, 0, 8,  0, 0, 0, 1, 0);
        add(3'b101, 0, 0, 6, 8,  0, 0, 0, 1, 0);
        // resync leaves FAULT but keeps err; err_clr on a legal step clears
        add(3'b101, 1, 0, 6, 8,  0, 0, 0, 1, 1);
        add(3'b100, 0, 1, 7, 9,  1, 0, 0, 0, 1);
        // resync to a distant value
        add(3'b000, 0, 0, 0, 10, 1, 0, 1, 0, 1);
        add(3'b001, 0, 0, 1, 11, 1, 0, 0, 0, 1);
        add(3'b111, 1, 0, 5, 11, 0, 0, 0, 0, 1);
        add(3'b111, 0, 0, 5, 11, 0, 0, 0, 0, 1);
        add(3'b001, 1, 0, 1, 11, 0, 0, 0, 0, 1);
        // resync with a +1 delta still gives no pulse
        add(3'b011, 1, 0, 2, 11, 0, 0, 0, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].g, vq[i].rs, vq[i].ec);
            chk_all($sformatf("vec%0d", i), vq[i].bin, vq[i].pos, vq[i].up,
                    vq[i].dn, vq[i].wr, vq[i].er, vq[i].lk);
        end

        // Asynchronous reset between edges
        do_reset();
        drive(3'b000, 0, 0);
        drive(3'b001, 0, 0);
        drive(3'b011, 0, 0);
        drive(3'b010, 0, 0);
        chk_all("pre_rst", 3, 3, 1, 0, 0, 0, 1);
        #2 reset = 1'b1;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(3'b011, 0, 0);
        chk_all("post_rst", 2, 0, 0, 0, 0, 0, 1);

        // Randomized run against the reference model
        do_reset();
        m_mode = 0; m_bin = 0; m_pos = 0; m_err = 0;
        for (int i = 0; i < 1500; i++) begin
            int r, nb;
            bit rs, ec;
            r = int'($urandom_range(0, 99));
            if (m_mode == 0)  nb = int'($urandom_range(0, 7));
            else if (r < 50)  nb = (m_bin + 1) % 8;
            else if (r < 72)  nb = (m_bin + 7) % 8;
            else if (r < 84)  nb = m_bin;
            else              nb = int'($urandom_range(0, 7));
            rs = ($urandom_range(0, 99) < 5);
            ec = ($urandom_range(0, 99) < 8);
            model_step(nb, rs, ec);
            drive(enc(nb), rs, ec);
            chk_all($sformatf("rnd%0d", i), m_bin, m_pos, m_up, m_dn, m_wr,
                    m_err, (m_mode == 1) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
